// File: rtl/ram_ctrl_pkg.sv
// Shared types and defaults for the dual-port RAM arbiter: FSM states, requester id, widths.
package ram_ctrl_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned ADDR_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_ID_0 = 1'b0,
        REQ_ID_1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/ram_dp_port_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: two request channels and their responses.
interface ram_dp_port_arbiter_if
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  req0_valid;
    logic                  req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;

    logic                  req1_valid;
    logic                  req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way grant logic: round-robin on ties, or fixed priority to requester 0 when
// RAM_ARB_FIXED_PRIO_EN is defined. grant_c is combinational one-hot.
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_ptr_inputs;
    assign unused_ptr_inputs = ^{clk, rst, accept};

    always_comb begin
        grant_c = 2'b00;
        if (req[0]) begin
            grant_c = 2'b01;
        end else if (req[1]) begin
            grant_c = 2'b10;
        end
    end
`else
    req_id_t last_q;

    // Last-grant pointer; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_ID_1;
        end else if (accept) begin
            last_q <= grant_c[1] ? REQ_ID_1 : REQ_ID_0;
        end
    end

    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = (last_q == REQ_ID_0) ? 2'b10 : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/ram_dp_port_arbiter.sv
// Arbitrates two requesters onto one asynchronous SRAM port, one access per 3 cycles.
// Tie-break mode selected by RAM_ARB_FIXED_PRIO_EN (see rr_arbiter2).
module ram_dp_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_dp_port_arbiter_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wdata_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy
);

    state_t                state_q, state_n;
    req_id_t               owner_q, owner_n;
    logic                  we_q, we_n;

    logic [1:0]            grant_c;
    logic                  accept_c;
    req_id_t               acc_id_c;
    logic                  acc_we_c;
    logic [ADDR_WIDTH-1:0] acc_addr_c;
    logic [DATA_WIDTH-1:0] acc_wdata_c;

    logic [ADDR_WIDTH-1:0] ram_address_n;
    logic [DATA_WIDTH-1:0] ram_wdata_n;
    logic                  ram_cs_n, ram_we_n, ram_oe_n, ram_wdata_oe_n, busy_n;
    logic [1:0]            rsp_valid_q, rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_n;
    logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_n;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({bus.req1_valid, bus.req0_valid}),
        .accept  (accept_c),
        .grant_c (grant_c)
    );

    // Ready is combinational and only offered while idle and out of reset.
    assign bus.req0_ready = (state_q == ST_IDLE) && !rst && grant_c[0];
    assign bus.req1_ready = (state_q == ST_IDLE) && !rst && grant_c[1];
    assign accept_c       = (bus.req0_valid && bus.req0_ready) ||
                            (bus.req1_valid && bus.req1_ready);

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;

    always_comb begin
        acc_id_c    = REQ_ID_0;
        acc_we_c    = bus.req0_we;
        acc_addr_c  = bus.req0_addr;
        acc_wdata_c = bus.req0_wdata;
        if (grant_c[1]) begin
            acc_id_c    = REQ_ID_1;
            acc_we_c    = bus.req1_we;
            acc_addr_c  = bus.req1_addr;
            acc_wdata_c = bus.req1_wdata;
        end
    end

    // Next state plus next value of every registered output (outputs follow the next state).
    always_comb begin
        state_n        = state_q;
        owner_n        = owner_q;
        we_n           = we_q;
        ram_address_n  = ram_address;
        ram_wdata_n    = ram_wdata;
        ram_cs_n       = 1'b0;
        ram_we_n       = 1'b0;
        ram_oe_n       = 1'b0;
        ram_wdata_oe_n = 1'b0;
        rsp_valid_n    = 2'b00;
        rsp0_rdata_n   = '0;
        rsp1_rdata_n   = '0;
        busy_n         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ram_address_n = '0;
                ram_wdata_n   = '0;
                if (accept_c) begin
                    state_n        = ST_ACCESS;
                    owner_n        = acc_id_c;
                    we_n           = acc_we_c;
                    ram_address_n  = acc_addr_c;
                    ram_wdata_n    = acc_wdata_c;
                    ram_cs_n       = 1'b1;
                    ram_we_n       = acc_we_c;
                    ram_oe_n       = !acc_we_c;
                    ram_wdata_oe_n = acc_we_c;
                end
            end
            ST_ACCESS: begin
                // Write data keeps driving the bus one cycle past we falling.
                state_n        = ST_DONE;
                ram_wdata_oe_n = we_q;
                if (owner_q == REQ_ID_1) begin
                    rsp_valid_n[1] = 1'b1;
                    rsp1_rdata_n   = we_q ? '0 : ram_rdata;
                end else begin
                    rsp_valid_n[0] = 1'b1;
                    rsp0_rdata_n   = we_q ? '0 : ram_rdata;
                end
            end
            ST_DONE: begin
                state_n       = ST_IDLE;
                ram_address_n = '0;
                ram_wdata_n   = '0;
            end
            default: begin
                state_n       = ST_IDLE;
                ram_address_n = '0;
                ram_wdata_n   = '0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_ID_0;
            we_q         <= 1'b0;
            ram_address  <= '0;
            ram_wdata    <= '0;
            ram_cs       <= 1'b0;
            ram_we       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_wdata_oe <= 1'b0;
            busy         <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            we_q         <= we_n;
            ram_address  <= ram_address_n;
            ram_wdata    <= ram_wdata_n;
            ram_cs       <= ram_cs_n;
            ram_we       <= ram_we_n;
            ram_oe       <= ram_oe_n;
            ram_wdata_oe <= ram_wdata_oe_n;
            busy         <= busy_n;
            rsp_valid_q  <= rsp_valid_n;
            rsp0_rdata_q <= rsp0_rdata_n;
            rsp1_rdata_q <= rsp1_rdata_n;
        end
    end

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Scoreboard bench for ram_dp_port_arbiter: transaction-level memory model plus pin-level RAM.
module tb_ram_dp_port_arbiter;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_address;
    logic          ram_cs, ram_we, ram_oe, ram_wdata_oe, busy;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_dp_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_dp_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_address  (ram_address),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_oe       (ram_oe),
        .ram_wdata    (ram_wdata),
        .ram_wdata_oe (ram_wdata_oe),
        .ram_rdata    (ram_rdata),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pin-level asynchronous SRAM
    logic [DW-1:0] phys_mem [DEPTH];
    logic [DW-1:0] ref_mem  [DEPTH];
    always @(posedge clk) if (ram_cs && ram_we) phys_mem[ram_address] <= ram_wdata;
    assign ram_rdata = (ram_cs && ram_oe) ? phys_mem[ram_address] : DW'(16'hDEAD);

    typedef struct { bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { int id; logic [DW-1:0] rdata; int cyc; } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic rst_d  = 1'b1;
    bit   mon_en = 1'b0;

    req_t pend0[$];
    req_t pend1[$];
    bit   hold0 = 1'b0;
    bit   hold1 = 1'b0;
    exp_t exp_q[$];
    int   grant_log[$];
    int   last_gnt = 1;

    bit            cur_valid = 1'b0;
    bit            cur_we    = 1'b0;
    logic [AW-1:0] cur_addr  = '0;
    logic [DW-1:0] cur_wdata = '0;
    int            acc_cyc   = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input bit we, input int addr, input int data);
        req_t r;
        r.we   = we;
        r.addr = AW'(addr);
        r.data = DW'(data);
        if (id == 0) pend0.push_back(r);
        else         pend1.push_back(r);
    endtask

    // Reference model of one accepted transaction
    task automatic accept(input int id);
        req_t r;
        exp_t e;
        if (id == 0) begin r = pend0.pop_front(); hold0 = 1'b0; end
        else         begin r = pend1.pop_front(); hold1 = 1'b0; end
        cur_valid = 1'b1;
        cur_we    = r.we;
        cur_addr  = r.addr;
        cur_wdata = r.data;
        acc_cyc   = cyc;
        last_gnt  = id;
        grant_log.push_back(id);
        e.id  = id;
        e.cyc = cyc + 2;
        if (r.we) begin
            ref_mem[r.addr] = r.data;
            e.rdata = '0;
        end else begin
            e.rdata = ref_mem[r.addr];
        end
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input bit gaps);
        logic [1:0] exp_rdy;
        bit         busy_exp;
        @(negedge clk);
        if (!hold0 && pend0.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) hold0 = 1'b1;
        if (!hold1 && pend1.size() > 0 && (!gaps || $urandom_range(0, 1) == 1)) hold1 = 1'b1;
        if (hold0) begin
            bus.req0_valid = 1'b1;
            bus.req0_we    = pend0[0].we;
            bus.req0_addr  = pend0[0].addr;
            bus.req0_wdata = pend0[0].data;
        end else begin
            bus.req0_valid = 1'b0;
            bus.req0_we    = 1'($urandom_range(0, 1));
            bus.req0_addr  = AW'($urandom);
            bus.req0_wdata = DW'($urandom);
        end
        if (hold1) begin
            bus.req1_valid = 1'b1;
            bus.req1_we    = pend1[0].we;
            bus.req1_addr  = pend1[0].addr;
            bus.req1_wdata = pend1[0].data;
        end else begin
            bus.req1_valid = 1'b0;
            bus.req1_we    = 1'($urandom_range(0, 1));
            bus.req1_addr  = AW'($urandom);
            bus.req1_wdata = DW'($urandom);
        end
        #1;
        busy_exp = cur_valid && ((cyc - acc_cyc) <= 2);
        if (busy_exp) begin
            exp_rdy = 2'b00;
        end else if (bus.req0_valid && bus.req1_valid) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_rdy = 2'b01;
`else
            exp_rdy = (last_gnt == 0) ? 2'b10 : 2'b01;
`endif
        end else begin
            exp_rdy = {bus.req1_valid, bus.req0_valid};
        end
        chk("ready", 32'({bus.req1_ready, bus.req0_ready}), 32'(exp_rdy));
        if (bus.req0_valid && bus.req0_ready)      accept(0);
        else if (bus.req1_valid && bus.req1_ready) accept(1);
    endtask

    task automatic drain(input bit gaps, input int budget);
        int n;
        n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0) && n < budget) begin
            drive_cycle(gaps);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout pend0=%0d pend1=%0d outstanding=%0d",
                     pend0.size(), pend1.size(), exp_q.size());
            pend0.delete(); pend1.delete(); exp_q.delete();
            hold0 = 1'b0; hold1 = 1'b0;
        end
        repeat (2) drive_cycle(gaps);
    endtask

    // Monitor: pin checks derived from the in-flight transaction, and scoreboard pops on rsp
    always @(negedge clk) begin
        if (mon_en) begin
            int   ph;
            bit   in_acc, in_done;
            exp_t e;
            ph      = cur_valid ? (cyc - acc_cyc) : 99;
            in_acc  = (ph == 1);
            in_done = (ph == 2);
            chk("ram_ctl{cs,we,oe,wdoe,busy}",
                32'({ram_cs, ram_we, ram_oe, ram_wdata_oe, busy}),
                32'({in_acc, in_acc && cur_we, in_acc && !cur_we,
                     (in_acc || in_done) && cur_we, in_acc || in_done}));
            if (in_acc || in_done) begin
                chk("ram_address", 32'(ram_address), 32'(cur_addr));
                if (cur_we) chk("ram_wdata", 32'(ram_wdata), 32'(cur_wdata));
            end
            if (rst_d) begin
                chk("rst_zero", 32'({ram_address, ram_wdata, ram_cs, ram_we, ram_oe, ram_wdata_oe,
                                     busy, bus.rsp0_valid, bus.rsp1_valid,
                                     bus.req0_ready, bus.req1_ready}), 32'(0));
                chk("rst_rdata", 32'({bus.rsp0_rdata, bus.rsp1_rdata}), 32'(0));
            end
            if (!bus.rsp0_valid) chk("rsp0_rdata_idle", 32'(bus.rsp0_rdata), 32'(0));
            if (!bus.rsp1_valid) chk("rsp1_rdata_idle", 32'(bus.rsp1_rdata), 32'(0));

            checks++;
            assert (!(ram_we && ram_oe)) else begin
                errors++;
                $display("FAIL we_oe_overlap we=%b oe=%b", ram_we, ram_oe);
            end
            checks++;
            assert (!(ram_we && !ram_cs)) else begin
                errors++;
                $display("FAIL we_without_cs we=%b cs=%b", ram_we, ram_cs);
            end
            checks++;
            assert (!(busy && (bus.req0_ready || bus.req1_ready))) else begin
                errors++;
                $display("FAIL ready_while_busy r0=%b r1=%b", bus.req0_ready, bus.req1_ready);
            end

            if (bus.rsp0_valid || bus.rsp1_valid) begin
                checks++;
                if (bus.rsp0_valid && bus.rsp1_valid) begin
                    errors++;
                    $display("FAIL rsp_both actual=11 expected=one-hot");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected rsp0=%b rsp1=%b cyc=%0d",
                             bus.rsp0_valid, bus.rsp1_valid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
                    chk("rsp_rdata", 32'(bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata),
                        32'(e.rdata));
                    chk("rsp_latency_cyc", 32'(cyc), 32'(e.cyc));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL rsp_missing id=%0d expected_cyc=%0d now=%0d", e.id, e.cyc, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int exp_g;
        for (int i = 0; i < int'(DEPTH); i++) begin
            phys_mem[i] = DW'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;

        repeat (3) @(negedge clk);
        #2 mon_en = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;

        // Directed write then read-back from the other requester
        push(0, 1'b1, 5, 16'hABCD);
        drain(1'b0, 50);
        push(1, 1'b0, 5, 0);
        drain(1'b0, 50);

        // Both requesters continuously valid
        grant_log.delete();
        for (int i = 0; i < 6; i++) begin
            push(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
            push(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom);
        end
        drain(1'b0, 400);
        for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            chk("grant_order", (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF,
                32'(exp_g));
        end

        // Reset during the ACCESS cycle of a read
        push(0, 1'b0, 5, 0);
        n0 = grant_log.size();
        for (int i = 0; i < 20 && grant_log.size() == n0; i++) drive_cycle(1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cur_valid = 1'b0;
        exp_q.delete();
        pend0.delete();
        pend1.delete();
        hold0 = 1'b0;
        hold1 = 1'b0;
        last_gnt = 1;
        @(negedge clk);
        #2 rst = 1'b0;
        push(1, 1'b0, 5, 0);
        push(0, 1'b1, 9, 16'h1234);
        drain(1'b0, 50);

        // Randomized traffic with random valid gaps
        for (int i = 0; i < 150; i++) begin
            push($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(DEPTH) - 1)
                                             : $urandom_range(0, 7),
                 $urandom);
        end
        drain(1'b1, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
